imc_buf_arbiter: RTL



---
 rtl/imc_buf_arbiter.sv | 106 ++++++++++
 1 files changed

// File: rtl/imc_buf_arbiter.sv
// imc_buf_arbiter: shares IM/WB/IB/OB between host and compute controller (controller wins) and tracks IM occupancy
module imc_buf_arbiter #(
  parameter int WIDTH_IM       = 32,
  parameter int WIDTH_BUF      = 16,
  parameter int WIDTH_IM_ADDR  = 6,
  parameter int WIDTH_BUF_ADDR = 4
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      h_req,
  input  logic                      h_we,
  input  logic [1:0]                h_sel,
  input  logic [WIDTH_IM_ADDR-1:0]  h_addr,
  input  logic [WIDTH_IM-1:0]       h_wdata,
  output logic                      h_ack,
  output logic                      h_err,
  output logic [WIDTH_IM-1:0]       h_rdata,
  input  logic                      c_im_rd_en,
  input  logic [WIDTH_IM_ADDR-1:0]  c_im_addr,
  input  logic                      c_wb_rd_en,
  input  logic                      c_ib_rd_en,
  input  logic                      c_ob_wr_en,
  input  logic                      c_sa_wr_en,
  input  logic [WIDTH_BUF_ADDR-1:0] c_buf_addr,
  output logic                      im_en,
  output logic                      im_we,
  output logic [WIDTH_IM_ADDR-1:0]  im_addr,
  output logic [WIDTH_IM-1:0]       im_wdata,
  input  logic [WIDTH_IM-1:0]       im_rdata,
  output logic [2:0]                buf_en,
  output logic                      buf_we,
  output logic [WIDTH_BUF_ADDR-1:0] buf_addr,
  output logic [WIDTH_BUF-1:0]      buf_wdata,
  input  logic [WIDTH_BUF-1:0]      ob_rdata,
  output logic                      IM_empty,
  output logic                      IM_full,
  output logic [WIDTH_IM_ADDR:0]    im_count
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  localparam logic [WIDTH_IM_ADDR:0]   DEPTH   = {1'b1, {WIDTH_IM_ADDR{1'b0}}};
  localparam logic [WIDTH_IM_ADDR:0]   CNT_ONE = {{WIDTH_IM_ADDR{1'b0}}, 1'b1};
  localparam logic [WIDTH_IM_ADDR-1:0] PTR_ONE = {{(WIDTH_IM_ADDR-1){1'b0}}, 1'b1};
  state_t                     state_q, state_d;
  logic [WIDTH_IM_ADDR-1:0]   wr_ptr_q;
  logic [WIDTH_IM_ADDR:0]     count_q, count_d;
  logic [WIDTH_IM-1:0]        rdata_q, rdata_d;
  logic                       c_im_rd_q, ack_q, err_q, empty_q, full_q;
  logic                       c_ctrl_busy, go, reject, host_acc, im_wr, rd_edge;
  assign c_ctrl_busy = c_im_rd_en | c_wb_rd_en | c_ib_rd_en | c_ob_wr_en | c_sa_wr_en;
  assign go          = (state_q == ACCESS) && !c_ctrl_busy;
  assign reject      = h_we ? (h_sel == 2'd3 || (h_sel == 2'd0 && full_q))
                            : (h_sel == 2'd1 || h_sel == 2'd2);
  assign host_acc    = go && !reject;
  assign im_wr       = host_acc && h_we && h_sel == 2'd0;
  assign rd_edge     = c_im_rd_en && !c_im_rd_q;
  // Host drives the macros only in an uncontended ACCESS cycle, so the two paths never overlap
  always_comb begin
    im_en     = c_im_rd_en | (host_acc && h_sel == 2'd0);
    im_we     = im_wr;
    im_addr   = c_ctrl_busy ? c_im_addr : (h_we ? wr_ptr_q : h_addr);
    im_wdata  = h_wdata;
    buf_en    = c_ctrl_busy ? {c_ob_wr_en | c_sa_wr_en, c_ib_rd_en, c_wb_rd_en}
              : host_acc    ? {h_sel == 2'd3, h_sel == 2'd2, h_sel == 2'd1} : 3'b000;
    buf_we    = c_ctrl_busy ? (c_ob_wr_en | c_sa_wr_en) : (host_acc && h_we && h_sel != 2'd0);
    buf_addr  = c_ctrl_busy ? c_buf_addr : h_addr[WIDTH_BUF_ADDR-1:0];
    buf_wdata = h_wdata[WIDTH_BUF-1:0];
  end
  always_comb begin
    state_d = state_q == IDLE   ? (h_req ? ACCESS : IDLE)
            : state_q == ACCESS ? (c_ctrl_busy ? ACCESS : RESP) : IDLE;
    rdata_d = (!host_acc || h_we) ? '0
            : h_sel == 2'd0 ? im_rdata : {{(WIDTH_IM-WIDTH_BUF){1'b0}}, ob_rdata};
    count_d = (im_wr == rd_edge) ? count_q
            : im_wr ? count_q + CNT_ONE
            : (count_q == '0 ? count_q : count_q - CNT_ONE);
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      c_im_rd_q <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= im_wr ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      count_q   <= count_d;
      c_im_rd_q <= c_im_rd_en;
      ack_q     <= go;
      err_q     <= go && reject;
      rdata_q   <= go ? rdata_d : rdata_q;
      empty_q   <= count_q == '0;
      full_q    <= count_q == DEPTH;
    end
  end
  assign h_ack    = ack_q;
  assign h_err    = err_q;
  assign h_rdata  = rdata_q;
  assign IM_empty = empty_q;
  assign IM_full  = full_q;
  assign im_count = count_q;
endmodule
